// File: rtl/cambricon_d_pkg.sv
// Shared types and helpers for the Cambricon-D delta encoder.
package cambricon_d_pkg;

    // Default datapath widths; the encoder output struct is sized with these.
    localparam int FULL_WIDTH_DEF  = 16;
    localparam int DELTA_WIDTH_DEF = 3;
    // Index field is wide enough for any practical frame length.
    localparam int IDX_W_MAX       = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [DELTA_WIDTH_DEF-1:0] delta;
        logic                       sign;
        logic                       outlier;
        logic [FULL_WIDTH_DEF-1:0]  full;
        logic [IDX_W_MAX-1:0]       index;
        logic                       last;
    } enc_out_t;

    // Clamp a signed value into the range representable by a dw-bit signed delta.
    function automatic logic signed [31:0] sat_delta(input logic signed [31:0] q,
                                                     input int                 dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (q > hi) begin
            sat_delta = hi;
        end else if (q < lo) begin
            sat_delta = lo;
        end else begin
            sat_delta = q;
        end
    endfunction

endpackage

// File: rtl/cambricon_d_ref_buffer.sv
// Per-element reference store: one synchronous read port, one write port.
// Contents are deliberately not reset; a first_step frame rebuilds them.
module cambricon_d_ref_buffer #(
    parameter int DEPTH = 16384,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage write port (RAM array, no reset).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (ren) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/cambricon_d_delta_encoder.sv
// Converts a frame of full-precision activations into narrow signed deltas
// against the previous frame's reconstruction. The reference is updated with
// the value the core will reconstruct, so quantisation error never drifts.
// FULL_WIDTH / DELTA_WIDTH are expected to equal the package defaults.
module cambricon_d_delta_encoder
    import cambricon_d_pkg::*;
#(
    parameter int VEC_LEN     = 16384,
    parameter int FULL_WIDTH  = FULL_WIDTH_DEF,
    parameter int DELTA_WIDTH = DELTA_WIDTH_DEF,
    parameter int SHIFT       = 0,
    parameter int IDX_W       = $clog2(VEC_LEN)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          first_step,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [FULL_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DELTA_WIDTH-1:0] out_delta,
    output logic                          out_sign,
    output logic                          out_outlier,
    output logic signed [FULL_WIDTH-1:0]  out_full,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic                          frame_done
);

    enc_state_e                  state_r;
    enc_state_e                  state_nxt_s;
    logic [IDX_W-1:0]            acc_cnt_r;
    logic                        first_step_r;
    logic                        frame_done_r;

    logic                        s1_valid_r;
    logic signed [FULL_WIDTH-1:0] s1_x_r;
    logic [IDX_W-1:0]            s1_idx_r;

    logic                        out_valid_r;
    enc_out_t                    out_r;
    logic [FULL_WIDTH-1:0]       ref_wdata_r;

    logic                        stall_s;
    logic                        adv_s;
    logic                        in_ready_s;
    logic                        in_hs_s;
    logic                        out_hs_s;
    logic                        last_acc_s;
    logic                        drain_done_s;

    logic [FULL_WIDTH-1:0]       ref_rdata_s;
    logic signed [FULL_WIDTH-1:0] ref_eff_s;
    logic signed [FULL_WIDTH:0]  diff_s;
    logic signed [FULL_WIDTH:0]  q_s;
    logic signed [31:0]          q_ext_s;
    logic signed [31:0]          sat_s;
    logic                        outlier_s;
    logic signed [FULL_WIDTH:0]  recon_s;
    logic [FULL_WIDTH-1:0]       ref_new_s;
    enc_out_t                    enc_nxt_s;

    // A held output freezes both pipeline stages and the reference write.
    assign stall_s      = out_valid_r & ~out_ready;
    assign adv_s        = ~stall_s;
    assign in_hs_s      = in_valid & in_ready_s;
    assign out_hs_s     = out_valid_r & out_ready;
    assign last_acc_s   = in_hs_s & (acc_cnt_r == IDX_W'(VEC_LEN - 1));
    assign drain_done_s = out_hs_s & (out_r.index == IDX_W_MAX'(VEC_LEN - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: start only counts in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (last_acc_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State-derived outputs: accept only while streaming and not stalled.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            STREAM:  in_ready_s = ~stall_s;
            IDLE:    in_ready_s = 1'b0;
            DRAIN:   in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Frame control: accept counter, latched first_step, end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_r    <= {IDX_W{1'b0}};
            first_step_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= (state_r == DRAIN) & drain_done_s;
            if ((state_r == IDLE) && start) begin
                acc_cnt_r    <= {IDX_W{1'b0}};
                first_step_r <= first_step;
            end else if (in_hs_s) begin
                acc_cnt_r <= acc_cnt_r + IDX_W'(1);
            end
        end
    end

    cambricon_d_ref_buffer #(
        .DEPTH (VEC_LEN),
        .WIDTH (FULL_WIDTH),
        .AW    (IDX_W)
    ) u_ref (
        .clk   (clk),
        .rst_n (rst_n),
        .ren   (in_hs_s),
        .raddr (acc_cnt_r),
        .rdata (ref_rdata_s),
        .we    (out_hs_s),
        .waddr (out_r.index[IDX_W-1:0]),
        .wdata (ref_wdata_r)
    );

    // Stage 1: capture the accepted activation and its index while the reference is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= {FULL_WIDTH{1'b0}};
            s1_idx_r   <= {IDX_W{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= in_hs_s;
            if (in_hs_s) begin
                s1_x_r   <= in_data;
                s1_idx_r <= acc_cnt_r;
            end
        end
    end

    // Stage 2 datapath: delta, floor quantise, saturate, closed-loop reconstruction.
    always_comb begin
        if (first_step_r) begin
            ref_eff_s = {FULL_WIDTH{1'b0}};
        end else begin
            ref_eff_s = ref_rdata_s;
        end
        diff_s    = {s1_x_r[FULL_WIDTH-1], s1_x_r} - {ref_eff_s[FULL_WIDTH-1], ref_eff_s};
        q_s       = diff_s >>> SHIFT;
        q_ext_s   = 32'(q_s);
        sat_s     = sat_delta(q_ext_s, DELTA_WIDTH);
        outlier_s = (sat_s != q_ext_s) | first_step_r;
        recon_s   = {ref_eff_s[FULL_WIDTH-1], ref_eff_s} + (q_s <<< SHIFT);
        if (outlier_s) begin
            ref_new_s = s1_x_r;
        end else begin
            ref_new_s = recon_s[FULL_WIDTH-1:0];
        end
        enc_nxt_s         = '0;
        enc_nxt_s.delta   = DELTA_WIDTH_DEF'(sat_s);
        enc_nxt_s.sign    = s1_x_r[FULL_WIDTH-1];
        enc_nxt_s.outlier = outlier_s;
        if (outlier_s) begin
            enc_nxt_s.full = FULL_WIDTH_DEF'(s1_x_r);
        end else begin
            enc_nxt_s.full = {FULL_WIDTH_DEF{1'b0}};
        end
        enc_nxt_s.index   = IDX_W_MAX'(s1_idx_r);
        enc_nxt_s.last    = (s1_idx_r == IDX_W'(VEC_LEN - 1));
    end

    // Stage 2 register: output element plus the reference value to commit on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
            ref_wdata_r <= {FULL_WIDTH{1'b0}};
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_r       <= enc_nxt_s;
                ref_wdata_r <= ref_new_s;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_delta   = DELTA_WIDTH'(out_r.delta);
    assign out_sign    = out_r.sign;
    assign out_outlier = out_r.outlier;
    assign out_full    = FULL_WIDTH'(out_r.full);
    assign out_index   = out_r.index[IDX_W-1:0];
    assign out_last    = out_r.last;
    assign busy        = (state_r != IDLE);
    assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_cambricon_d_delta_encoder.sv
// Bench: unit 0 is VEC_LEN=4/SHIFT=0, unit 1 is VEC_LEN=4/SHIFT=2.
module tb_cambricon_d_delta_encoder;

    localparam int VL = 4;
    localparam int FW = 16;
    localparam int DW = 3;
    localparam int IW = 2;
    localparam int QD = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 start[2], first_step[2], in_valid[2], in_ready[2];
    logic                 out_valid[2], out_ready[2], out_sign[2], out_outlier[2];
    logic                 out_last[2], busy[2], frame_done[2];
    logic signed [FW-1:0] in_data[2], out_full[2];
    logic signed [DW-1:0] out_delta[2];
    logic [IW-1:0]        out_index[2];

    cambricon_d_delta_encoder #(.VEC_LEN(VL), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .first_step(first_step[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_delta(out_delta[0]),
        .out_sign(out_sign[0]), .out_outlier(out_outlier[0]), .out_full(out_full[0]),
        .out_index(out_index[0]), .out_last(out_last[0]), .busy(busy[0]),
        .frame_done(frame_done[0]));

    cambricon_d_delta_encoder #(.VEC_LEN(VL), .SHIFT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .first_step(first_step[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_delta(out_delta[1]),
        .out_sign(out_sign[1]), .out_outlier(out_outlier[1]), .out_full(out_full[1]),
        .out_index(out_index[1]), .out_last(out_last[1]), .busy(busy[1]),
        .frame_done(frame_done[1]));

    typedef struct {
        int delta; int sign; int outlier; int full; int index; int last;
    } exp_t;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t eq[2][QD];
    int   wr[2], rd[2], fd_cnt[2], macc[2], gcnt[2];
    bit   mfs[2], m_busy[2];
    int   mref[2][VL];
    int   glog_d[2][VL], glog_o[2][VL], glog_f[2][VL], glog_s[2][VL];
    int   xv[VL], ed[VL], eo[VL], ef[VL], es[VL];

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // Reference behaviour: x minus previous reconstruction, floor divide by step, clamp.
    task automatic model_push(input int u);
        int x, r, d, q, sat, step;
        bit o;
        exp_t e;
        step = (u == 0) ? 1 : 4;
        x = int'(in_data[u]);
        r = mfs[u] ? 0 : mref[u][macc[u] % VL];
        d = x - r;
        if (d >= 0) q = d / step;
        else        q = -((-d + step - 1) / step);
        sat = (q > 3) ? 3 : ((q < -4) ? -4 : q);
        o = (sat != q) || mfs[u];
        e.delta   = sat;
        e.sign    = (x < 0) ? 1 : 0;
        e.outlier = o ? 1 : 0;
        e.full    = o ? x : 0;
        e.index   = macc[u];
        e.last    = (macc[u] == VL - 1) ? 1 : 0;
        mref[u][macc[u] % VL] = o ? x : r + sat * step;
        eq[u][wr[u] % QD] = e;
        wr[u]++;
        macc[u]++;
    endtask

    task automatic model_pop(input int u);
        exp_t e;
        int gd, gs, go, gf, gi, gl;
        n_chk++;
        if (rd[u] == wr[u]) begin
            n_err++;
            $display("FAIL out_unexpected u%0d index=%0d", u, out_index[u]);
        end else begin
            e  = eq[u][rd[u] % QD];
            rd[u]++;
            gd = int'(out_delta[u]); gs = int'(out_sign[u]); go = int'(out_outlier[u]);
            gf = int'(out_full[u]);  gi = int'(out_index[u]); gl = int'(out_last[u]);
            if (gd != e.delta || gs != e.sign || go != e.outlier || gf != e.full ||
                gi != e.index || gl != e.last) begin
                n_err++;
                $display("FAIL out_elem u%0d got d=%0d s=%0d o=%0d f=%0d i=%0d l=%0d expected d=%0d s=%0d o=%0d f=%0d i=%0d l=%0d",
                         u, gd, gs, go, gf, gi, gl, e.delta, e.sign, e.outlier, e.full, e.index, e.last);
            end
            if (gcnt[u] < VL) begin
                glog_d[u][gcnt[u]] = gd; glog_o[u][gcnt[u]] = go;
                glog_f[u][gcnt[u]] = gf; glog_s[u][gcnt[u]] = gs;
            end
            gcnt[u]++;
            if (e.last == 1) m_busy[u] = 1'b0;
        end
    endtask

    // Scoreboard process: sampled on the falling edge, away from the active edge.
    initial begin
        for (int u = 0; u < 2; u++) begin
            wr[u] = 0; rd[u] = 0; fd_cnt[u] = 0; macc[u] = 0; gcnt[u] = 0;
            mfs[u] = 1'b0; m_busy[u] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (!rst_n) begin
                    m_busy[u] = 1'b0;
                    rd[u] = wr[u];
                end else begin
                    if (frame_done[u]) fd_cnt[u]++;
                    if (!m_busy[u] && start[u]) begin
                        m_busy[u] = 1'b1; mfs[u] = first_step[u]; macc[u] = 0; gcnt[u] = 0;
                    end
                    if (out_valid[u] && !out_ready[u]) chk("stall_in_ready", int'(in_ready[u]), 0);
                    if (in_valid[u] && in_ready[u]) model_push(u);
                    if (out_valid[u] && out_ready[u]) model_pop(u);
                end
            end
        end
    end

    task automatic chk_reset(input int u, input string nm);
        chk({nm, "_out_valid"}, int'(out_valid[u]), 0);
        chk({nm, "_in_ready"}, int'(in_ready[u]), 0);
        chk({nm, "_busy"}, int'(busy[u]), 0);
        chk({nm, "_frame_done"}, int'(frame_done[u]), 0);
        chk({nm, "_delta"}, int'(out_delta[u]), 0);
        chk({nm, "_full"}, int'(out_full[u]), 0);
        chk({nm, "_idx_flags"}, int'({out_index[u], out_sign[u], out_outlier[u], out_last[u]}), 0);
    endtask

    // Runs one frame of xv on unit u with an optional stall window and mid-frame start.
    task automatic run_frame(input int u, input bit fs, input int stall_at,
                             input int stall_len, input bit glitch);
        int  i = 0;
        int  cyc = 0;
        int  base;
        bit  seen = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy[u]), 0);
        chk("idle_in_ready", int'(in_ready[u]), 0);
        @(posedge clk); #1;
        start[u] = 1'b1; first_step[u] = fs;
        base = fd_cnt[u];
        @(posedge clk); #1;
        while (!seen && cyc < 60) begin
            out_ready[u] = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (i < VL) begin
                in_valid[u] = 1'b1; in_data[u] = FW'(xv[i]);
            end else begin
                in_valid[u] = 1'b0;
            end
            if (glitch && cyc == 1) begin
                start[u] = 1'b1; first_step[u] = !fs;
            end else begin
                start[u] = 1'b0; first_step[u] = 1'b0;
            end
            @(negedge clk);
            if (frame_done[u]) begin
                chk("done_busy", int'(busy[u]), 0);
                seen = 1'b1;
            end else begin
                chk("frame_busy", int'(busy[u]), 1);
            end
            if (i >= VL) chk("drain_in_ready", int'(in_ready[u]), 0);
            if (in_valid[u] && in_ready[u]) i++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid[u] = 1'b0; start[u] = 1'b0; first_step[u] = 1'b0; out_ready[u] = 1'b1;
        if (!seen) chk("frame_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("frame_done_pulses", fd_cnt[u] - base, 1);
        chk("pending_outputs", wr[u] - rd[u], 0);
    endtask

    task automatic lit(input int u, input string nm);
        chk({nm, "_count"}, gcnt[u], VL);
        for (int k = 0; k < VL; k++) begin
            chk($sformatf("%s_delta%0d", nm, k), glog_d[u][k], ed[k]);
            chk($sformatf("%s_outlier%0d", nm, k), glog_o[u][k], eo[k]);
            chk($sformatf("%s_full%0d", nm, k), glog_f[u][k], ef[k]);
            chk($sformatf("%s_sign%0d", nm, k), glog_s[u][k], es[k]);
        end
    endtask

    task automatic set_u1(input int x, input int d, input int o);
        for (int k = 0; k < VL; k++) begin
            xv[k] = x; ed[k] = d; eo[k] = o; ef[k] = (o != 0) ? x : 0; es[k] = (x < 0) ? 1 : 0;
        end
    endtask

    task automatic reset_mid_frame();
        int acc = 0;
        int guard = 0;
        int base;
        xv = '{7, 8, 9, 10};
        @(posedge clk); #1;
        start[0] = 1'b1; first_step[0] = 1'b0;
        @(posedge clk); #1;
        start[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = FW'(xv[0]); out_ready[0] = 1'b1;
        while (acc < 2 && guard < 20) begin
            @(negedge clk);
            if (in_valid[0] && in_ready[0]) acc++;
            @(posedge clk); #1;
            guard++;
            in_data[0] = FW'(xv[acc]);
        end
        chk("midrst_accepted", acc, 2);
        in_valid[0] = 1'b0;
        base = fd_cnt[0];
        rst_n = 1'b0;
        #1;
        chk_reset(0, "midrst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", fd_cnt[0], base);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; first_step[u] = 1'b0; in_valid[u] = 1'b0;
            in_data[u] = '0; out_ready[u] = 1'b1;
        end
        #2;
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First step: every element is an outlier carrying x.
        xv = '{10, -5, 0, 100}; ed = '{3, -4, 0, 3}; eo = '{1, 1, 1, 1};
        ef = '{10, -5, 0, 100}; es = '{0, 1, 0, 0};
        run_frame(0, 1'b1, 99, 0, 1'b0);
        lit(0, "first");

        // Delta frame against the reconstructed reference.
        xv = '{12, -6, 4, 97}; ed = '{2, -1, 3, -3}; eo = '{0, 0, 1, 0};
        ef = '{0, 0, 4, 0}; es = '{0, 1, 0, 0};
        run_frame(0, 1'b0, 99, 0, 1'b0);
        lit(0, "delta");

        // Same input again: zero deltas.
        ed = '{0, 0, 0, 0}; eo = '{0, 0, 0, 0}; ef = '{0, 0, 0, 0};
        run_frame(0, 1'b0, 99, 0, 1'b0);
        lit(0, "repeat");

        // Backpressure: out_ready low for 3 cycles mid-frame.
        xv = '{15, -9, -100, 97}; ed = '{3, -3, -4, 0}; eo = '{0, 0, 1, 0};
        ef = '{0, 0, -100, 0}; es = '{0, 1, 1, 0};
        run_frame(0, 1'b0, 3, 3, 1'b0);
        lit(0, "stall");

        // Same input with a stray start/first_step during STREAM: must be ignored.
        ed = '{0, 0, 0, 0}; eo = '{0, 0, 0, 0}; ef = '{0, 0, 0, 0};
        run_frame(0, 1'b0, 99, 0, 1'b1);
        lit(0, "after_stall");

        // SHIFT=2 closed-loop sequence.
        set_u1(0, 0, 1);
        run_frame(1, 1'b1, 99, 0, 1'b0);
        lit(1, "s2_first");
        set_u1(5, 1, 0);
        run_frame(1, 1'b0, 99, 0, 1'b0);
        lit(1, "s2_up");
        set_u1(5, 0, 0);
        run_frame(1, 1'b0, 99, 0, 1'b0);
        lit(1, "s2_hold");
        set_u1(-5, -3, 0);
        run_frame(1, 1'b0, 99, 0, 1'b0);
        lit(1, "s2_neg");
        set_u1(-8, 0, 0);
        run_frame(1, 1'b0, 99, 0, 1'b0);
        lit(1, "s2_ref_m8");

        // Reset mid-frame, then a clean first_step frame.
        reset_mid_frame();
        xv = '{1, 2, 3, -3}; ed = '{1, 2, 3, -3}; eo = '{1, 1, 1, 1};
        ef = '{1, 2, 3, -3}; es = '{0, 0, 0, 1};
        run_frame(0, 1'b1, 2, 2, 1'b0);
        lit(0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
